// File: rtl/vm_pkg.sv
// =============================================================================
// Module      : vm_pkg
// Description : Shared constants for the change dispenser: coin values,
//               denomination indices, FSM state encoding.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package vm_pkg;

    localparam int unsigned c_val_500 = 500;
    localparam int unsigned c_val_100 = 100;
    localparam int unsigned c_val_50  = 50;
    localparam int unsigned c_val_10  = 10;

    // Index order matches the coin_eject / stock_empty bit order
    localparam logic [1:0] c_idx_10  = 2'd0;
    localparam logic [1:0] c_idx_50  = 2'd1;
    localparam logic [1:0] c_idx_100 = 2'd2;
    localparam logic [1:0] c_idx_500 = 2'd3;

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_select = 3'd1;
    localparam logic [2:0] c_st_eject  = 3'd2;
    localparam logic [2:0] c_st_gap    = 3'd3;
    localparam logic [2:0] c_st_done   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = c_st_idle,
        ST_SELECT = c_st_select,
        ST_EJECT  = c_st_eject,
        ST_GAP    = c_st_gap,
        ST_DONE   = c_st_done
    } state_t;

    function automatic logic [15:0] coin_value(input logic [1:0] idx);
        logic [15:0] val;
        case (idx)
            c_idx_500: val = 16'(c_val_500);
            c_idx_100: val = 16'(c_val_100);
            c_idx_50:  val = 16'(c_val_50);
            default:   val = 16'(c_val_10);
        endcase
        return val;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vm_coin_stock.sv
// =============================================================================
// Module      : vm_coin_stock
// Description : Four saturating coin stock counters with refill/decrement.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module vm_coin_stock #(
    parameter int STK_W      = 8,
    parameter int INIT_STOCK = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_refill_en,
    input  logic [1:0]       i_refill_sel,
    input  logic [STK_W-1:0] i_refill_cnt,
    input  logic             i_dec_en,
    input  logic [1:0]       i_dec_sel,
    output logic [STK_W-1:0] o_stock [4],
    output logic [3:0]       o_empty
);
    import vm_pkg::*;

    localparam logic [STK_W:0]   c_max  = {1'b0, {STK_W{1'b1}}};
    localparam logic [STK_W:0]   c_one  = (STK_W+1)'(1);
    localparam logic [STK_W-1:0] c_init = STK_W'(INIT_STOCK);

    for (genvar g = 0; g < 4; g++) begin : g_den
        logic [STK_W-1:0] stock_q;
        logic [STK_W-1:0] stock_d;
        logic [STK_W:0]   w_sum;

        // One extra bit holds stock+refill so saturation can be detected
        assign w_sum = {1'b0, stock_q}
                     + ((i_refill_en && i_refill_sel == 2'(g)) ? {1'b0, i_refill_cnt} : '0)
                     - ((i_dec_en && i_dec_sel == 2'(g)) ? c_one : '0);

        always_comb begin
            stock_d = w_sum[STK_W-1:0];
            if (w_sum > c_max) begin
                stock_d = '1;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                stock_q <= c_init;
            end else begin
                stock_q <= stock_d;
            end
        end

        assign o_stock[g] = stock_q;
        assign o_empty[g] = (stock_q == '0);
    end

endmodule

`default_nettype wire

// File: rtl/vm_change_dispenser.sv
// =============================================================================
// Module      : vm_change_dispenser
// Description : Pays out change one coin at a time, largest denomination first.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module vm_change_dispenser #(
    parameter int AMT_W        = 11,
    parameter int STK_W        = 8,
    parameter int INIT_STOCK   = 20,
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [AMT_W-1:0] req_amount,
    output logic [3:0]       coin_eject,
    output logic             busy,
    output logic             done,
    output logic             short,
    output logic [AMT_W-1:0] remain,
    input  logic             refill_en,
    input  logic [1:0]       refill_sel,
    input  logic [STK_W-1:0] refill_cnt,
    output logic [3:0]       stock_empty
);
    import vm_pkg::*;

    localparam int c_cnt_max = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
    localparam logic [c_cnt_w-1:0] c_pulse_last = c_cnt_w'(PULSE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_gap_last   = c_cnt_w'(GAP_CYCLES - 1);

    state_t             state_q, state_d;
    logic [AMT_W-1:0]   remain_q, remain_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic [3:0]         coin_eject_q, coin_eject_d;
    logic               done_q, done_d;
    logic               short_q, short_d;

    logic               w_found;
    logic [1:0]         w_sel;
    logic               w_dec_en;
    logic [STK_W-1:0]   stock [4];

    vm_coin_stock #(
        .STK_W      (STK_W),
        .INIT_STOCK (INIT_STOCK)
    ) u_stock (
        .clk          (clk),
        .rst          (reset),
        .i_refill_en  (refill_en),
        .i_refill_sel (refill_sel),
        .i_refill_cnt (refill_cnt),
        .i_dec_en     (w_dec_en),
        .i_dec_sel    (w_sel),
        .o_stock      (stock),
        .o_empty      (stock_empty)
    );

    // Ascending scan: the last hit is the largest payable denomination
    always_comb begin
        w_found = 1'b0;
        w_sel   = c_idx_10;
        for (int i = 0; i < 4; i++) begin
            if (stock[i] != '0 && AMT_W'(coin_value(2'(i))) <= remain_q) begin
                w_found = 1'b1;
                w_sel   = 2'(i);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        remain_d     = remain_q;
        cnt_d        = cnt_q;
        coin_eject_d = coin_eject_q;
        done_d       = 1'b0;
        short_d      = short_q;
        w_dec_en     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    remain_d = req_amount;
                    short_d  = 1'b0;
                    state_d  = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (w_found) begin
                    w_dec_en     = 1'b1;
                    remain_d     = remain_q - AMT_W'(coin_value(w_sel));
                    cnt_d        = '0;
                    coin_eject_d = 4'b0001 << w_sel;
                    state_d      = ST_EJECT;
                end else begin
                    short_d = (remain_q != '0);
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_EJECT: begin
                if (cnt_q == c_pulse_last) begin
                    cnt_d        = '0;
                    coin_eject_d = 4'b0000;
                    state_d      = ST_GAP;
                end else begin
                    cnt_d = cnt_q + c_cnt_w'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == c_gap_last) begin
                    cnt_d   = '0;
                    state_d = ST_SELECT;
                end else begin
                    cnt_d = cnt_q + c_cnt_w'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                coin_eject_d = 4'b0000;
                state_d      = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            remain_q     <= '0;
            cnt_q        <= '0;
            coin_eject_q <= 4'b0000;
            done_q       <= 1'b0;
            short_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            remain_q     <= remain_d;
            cnt_q        <= cnt_d;
            coin_eject_q <= coin_eject_d;
            done_q       <= done_d;
            short_q      <= short_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign coin_eject = coin_eject_q;
    assign done       = done_q;
    assign short      = short_q;
    assign remain     = remain_q;

endmodule

`default_nettype wire
